// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, validates 11-bit frames and buffers bytes.
// Optional `PS2_BREAK_FILTER_EN drops 0xF0 break prefixes and the byte that follows each one.
module ps2_scancode_rx #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          r_clk_s1, r_clk_s2, r_clk_hist;
   logic          r_dat_s1, r_dat_s2;
   logic [3:0]    r_bit_cnt;
   logic [9:0]    r_shift;
   logic [TW-1:0] r_idle;
   logic          r_frame_err;
   logic          r_overflow;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wptr, r_rptr;

   logic       w_fall, w_bit, w_last, w_good, w_bad, w_timeout;
   logic [7:0] w_byte;
   logic       w_push_req, w_push, w_pop, w_empty, w_full;

   // Preset to 1 so reset looks like an idle bus and cannot fake a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_hist <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_hist <= r_clk_s2;
         r_dat_s1   <= ps2_data;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall = r_clk_hist & ~r_clk_s2;
   assign w_bit  = r_dat_s2;
   assign w_last = w_fall && (r_bit_cnt == 4'd10);

   // After ten shifts: [0]=start, [8:1]=data, [9]=parity; the stop bit is the live sample.
   assign w_byte    = r_shift[8:1];
   assign w_good    = w_last & ~r_shift[0] & w_bit & (^r_shift[9:1]);
   assign w_bad     = w_last & ~w_good;
   assign w_timeout = !w_fall && (r_bit_cnt != 4'd0) && (r_idle == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt   <= 4'd0;
         r_shift     <= '0;
         r_idle      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_bad | w_timeout;
         if (w_fall) begin
            r_shift   <= {w_bit, r_shift[9:1]};
            r_bit_cnt <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
            r_idle    <= '0;
         end else if (w_timeout) begin
            r_bit_cnt <= 4'd0;
            r_idle    <= '0;
         end else if (r_bit_cnt != 4'd0) begin
            r_idle <= r_idle + TW'(1);
         end
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   logic r_brk_armed;
   logic w_brk_armed_nxt;

   always_comb begin
      w_push_req      = 1'b0;
      w_brk_armed_nxt = r_brk_armed;
      if (w_good) begin
         if (r_brk_armed) begin
            w_brk_armed_nxt = 1'b0;
         end else if (w_byte == 8'hF0) begin
            w_brk_armed_nxt = 1'b1;
         end else begin
            w_push_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_brk_armed <= 1'b0;
      else     r_brk_armed <= w_brk_armed_nxt;
   end
`else
   assign w_push_req = w_good;
`endif

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = ~w_empty & out_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign w_push  = w_push_req & (~w_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_byte;
            r_wptr                <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
         if (w_push_req && !w_push) r_overflow <= 1'b1;
      end
   end

   assign out_valid = ~w_empty;
   assign out_data  = r_mem[r_rptr[AW-1:0]];
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule
